// File: rtl/icetap_capture_ctrl.sv
// rtl/icetap_capture_ctrl.sv - icetap capture sequencer: circular BRAM writer with pre/post-trigger split and readout
// Runs entirely in the src_clk domain.
module icetap_capture_ctrl #(
  parameter int RECORD_DEPTH  = 256,
  parameter int RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
) (
  input  logic                     src_clk,
  input  logic                     src_reset_,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               trigger_pos,
  input  logic                     store_hit,
  input  logic                     trigger_hit,
  output logic                     ram_wr_ena,
  output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
  output logic                     ram_rd_ena,
  output logic [RAM_ADDR_BITS-1:0] ram_rd_addr,
  output logic [1:0]               state,
  output logic [RAM_ADDR_BITS-1:0] start_addr,
  output logic [RAM_ADDR_BITS-1:0] trigger_addr,
  output logic [RAM_ADDR_BITS-1:0] stop_addr,
  input  logic                     signals_out_req,
  output logic                     signals_out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [RAM_ADDR_BITS:0]   L_DEPTH = {1'b1, {RAM_ADDR_BITS{1'b0}}};
  localparam logic [RAM_ADDR_BITS:0]   L_CNT1  = {{RAM_ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [RAM_ADDR_BITS-1:0] L_AINC  = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

  state_t                   r_state;
  logic [RAM_ADDR_BITS-1:0] r_pre;
  logic [RAM_ADDR_BITS-1:0] r_wr_ptr;
  logic [RAM_ADDR_BITS-1:0] r_rd_ptr;
  logic [RAM_ADDR_BITS:0]   r_fill;
  logic [RAM_ADDR_BITS:0]   r_post_cnt;
  logic [RAM_ADDR_BITS-1:0] r_start_addr;
  logic [RAM_ADDR_BITS-1:0] r_trig_addr;
  logic [RAM_ADDR_BITS-1:0] r_stop_addr;
  logic                     r_ready;

  logic [RAM_ADDR_BITS-1:0] w_pre_sel;
  logic [RAM_ADDR_BITS-1:0] w_start_calc;
  logic                     w_cmd;
  logic                     w_trig_acc;

  always_comb begin
    w_pre_sel = '0;
    case (trigger_pos)
      2'd0:    w_pre_sel = '0;
      2'd2:    w_pre_sel = '1;
      default: w_pre_sel = {1'b1, {(RAM_ADDR_BITS-1){1'b0}}};
    endcase
  end

  // Command cycles never store or read: start/abort reset the sequence first.
  assign w_cmd        = start | abort;
  assign w_trig_acc   = (r_state == S_WAIT) && trigger_hit && (r_fill >= {1'b0, r_pre});
  assign w_start_calc = r_wr_ptr - r_pre;

  assign ram_wr_ena = !w_cmd &&
                      (((r_state == S_WAIT) && (store_hit || w_trig_acc)) ||
                       ((r_state == S_POST) && store_hit));
  assign ram_rd_ena = !w_cmd && (r_state == S_DONE) && signals_out_req && !r_ready;

  assign ram_wr_addr       = r_wr_ptr;
  assign ram_rd_addr       = r_rd_ptr;
  assign state             = r_state;
  assign start_addr        = r_start_addr;
  assign trigger_addr      = r_trig_addr;
  assign stop_addr         = r_stop_addr;
  assign signals_out_ready = r_ready;

  always_ff @(posedge src_clk or negedge src_reset_) begin
    if (!src_reset_) begin
      r_state      <= S_IDLE;
      r_pre        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_post_cnt   <= '0;
      r_start_addr <= '0;
      r_trig_addr  <= '0;
      r_stop_addr  <= '0;
      r_ready      <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else if (start) begin
      r_state      <= S_WAIT;
      r_pre        <= w_pre_sel;
      // POST = DEPTH-1-PRE, which is the bitwise complement of PRE.
      r_post_cnt   <= {1'b0, ~w_pre_sel};
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_start_addr <= '0;
      r_trig_addr  <= '0;
      r_stop_addr  <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (ram_wr_ena) begin
        r_wr_ptr <= r_wr_ptr + L_AINC;
        if (r_fill != L_DEPTH)
          r_fill <= r_fill + L_CNT1;
      end
      case (r_state)
        S_WAIT: begin
          if (w_trig_acc) begin
            r_trig_addr  <= r_wr_ptr;
            r_start_addr <= w_start_calc;
            if (r_post_cnt == '0) begin
              r_stop_addr <= r_wr_ptr;
              r_rd_ptr    <= w_start_calc;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (ram_wr_ena) begin
            r_post_cnt <= r_post_cnt - L_CNT1;
            if (r_post_cnt == L_CNT1) begin
              r_stop_addr <= r_wr_ptr;
              r_rd_ptr    <= r_start_addr;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (ram_rd_ena) begin
            r_ready  <= 1'b1;
            r_rd_ptr <= r_rd_ptr + L_AINC;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// tb/tb_icetap_capture_ctrl.sv - scoreboard bench for icetap_capture_ctrl at DEPTH=16
module tb_icetap_capture_ctrl;

  localparam int DEPTH = 16;
  localparam int AB    = 4;

  logic          src_clk = 1'b0;
  logic          src_reset_;
  logic          start, abort, store_hit, trigger_hit, signals_out_req;
  logic [1:0]    trigger_pos;
  logic          ram_wr_ena, ram_rd_ena, signals_out_ready;
  logic [AB-1:0] ram_wr_addr, ram_rd_addr, start_addr, trigger_addr, stop_addr;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;
  logic          mon_en  = 1'b0;
  logic          prev_rd = 1'b0;
  logic [AB-1:0] wq[$];
  logic [AB-1:0] rq[$];

  icetap_capture_ctrl #(.RECORD_DEPTH(DEPTH)) dut (
    .src_clk(src_clk), .src_reset_(src_reset_), .start(start), .abort(abort),
    .trigger_pos(trigger_pos), .store_hit(store_hit), .trigger_hit(trigger_hit),
    .ram_wr_ena(ram_wr_ena), .ram_wr_addr(ram_wr_addr), .ram_rd_ena(ram_rd_ena),
    .ram_rd_addr(ram_rd_addr), .state(state), .start_addr(start_addr),
    .trigger_addr(trigger_addr), .stop_addr(stop_addr),
    .signals_out_req(signals_out_req), .signals_out_ready(signals_out_ready)
  );

  always #5 src_clk = ~src_clk;

  // Monitor: every presented write/read is matched against the expected queues.
  always @(negedge src_clk) begin
    logic [AB-1:0] e;
    if (mon_en) begin
      if (ram_wr_ena) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%0d required=no write", ram_wr_addr);
        end else begin
          e = wq.pop_front();
          if (ram_wr_addr !== e) begin
            bad++;
            $display("FAIL wr_addr got=%0d exp=%0d", ram_wr_addr, e);
          end
        end
      end
      if (ram_rd_ena) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read addr=%0d required=no read", ram_rd_addr);
        end else begin
          e = rq.pop_front();
          if (ram_rd_addr !== e) begin
            bad++;
            $display("FAIL rd_addr got=%0d exp=%0d", ram_rd_addr, e);
          end
        end
      end
      if (signals_out_ready || prev_rd) begin
        total++;
        if (signals_out_ready !== prev_rd) begin
          bad++;
          $display("FAIL ready_timing got=%0d exp=%0d", signals_out_ready, prev_rd);
        end
      end
      prev_rd = ram_rd_ena;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic [1:0] tp,
                      input logic sh, input logic th, input logic rqv);
    start = s; abort = a; trigger_pos = tp;
    store_hit = sh; trigger_hit = th; signals_out_req = rqv;
    @(posedge src_clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic chk_addrs(input string nm, input int st, input int sa, input int ta, input int pa);
    chk({nm, "_state"}, state, st);
    chk({nm, "_start_addr"}, start_addr, sa);
    chk({nm, "_trigger_addr"}, trigger_addr, ta);
    chk({nm, "_stop_addr"}, stop_addr, pa);
  endtask

  initial begin
    src_reset_ = 1'b0; start = 1'b0; abort = 1'b0; trigger_pos = 2'd0;
    store_hit = 1'b1; trigger_hit = 1'b1; signals_out_req = 1'b1;
    repeat (2) @(posedge src_clk);
    #1;
    chk_addrs("reset", 0, 0, 0, 0);
    chk("reset_wr_ena", ram_wr_ena, 0);
    chk("reset_ready", signals_out_ready, 0);
    src_reset_ = 1'b1;
    mon_en = 1'b1;
    step(0, 0, 0, 1, 1, 1);
    chk("idle_state", state, 0);

    // Middle trigger: PRE=8, early trigger at fill=3 ignored, accepted at fill=10
    step(1, 0, 2'd1, 1, 1, 0);
    chk("mid_state_wait", state, 1);
    for (int i = 0; i < 18; i++) begin
      wq.push_back(AB'(i % DEPTH));
      step(0, 0, 2'd1, 1, (i == 3 || i == 10), 0);
      if (i == 3)  chk("mid_early_trig_ignored", state, 1);
      if (i == 10) chk_addrs("mid_trig", 2, 2, 10, 0);
    end
    chk_addrs("mid_done", 3, 2, 10, 1);
    step(0, 0, 2'd1, 1, 1, 0);

    // Readout from start_addr=2; a second request during ready is dropped
    for (int k = 0; k < 16; k++) begin
      rq.push_back(AB'((2 + k) % DEPTH));
      step(0, 0, 2'd1, 0, 0, 1);
      step(0, 0, 2'd1, 0, 0, 1);
    end
    step(0, 0, 2'd1, 0, 0, 0);

    // Trigger at start: PRE=0, trigger sample stored with store_hit=0; requests ignored while capturing
    step(1, 0, 2'd0, 1, 1, 1);
    wq.push_back(AB'(0));
    step(0, 0, 2'd0, 0, 1, 1);
    chk_addrs("start_trig", 2, 0, 0, 0);
    for (int i = 1; i < 16; i++) begin
      wq.push_back(AB'(i));
      step(0, 0, 2'd0, 1, 0, 1);
    end
    chk_addrs("start_done", 3, 0, 0, 15);
    step(0, 0, 2'd0, 0, 0, 0);

    // Trigger at end: PRE=15, POST=0
    step(1, 0, 2'd2, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      wq.push_back(AB'(i % DEPTH));
      step(0, 0, 2'd2, 1, 0, 0);
    end
    chk("end_state_wait", state, 1);
    wq.push_back(AB'(4));
    step(0, 0, 2'd2, 0, 1, 0);
    chk_addrs("end_done", 3, 5, 4, 4);
    rq.push_back(AB'(5));
    step(0, 0, 2'd2, 1, 0, 1);
    step(0, 0, 2'd2, 1, 0, 0);

    // Gapped stores in POST_TRIGGER; trigger accepted exactly at fill==PRE
    step(1, 0, 2'd1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      wq.push_back(AB'(i));
      step(0, 0, 2'd1, 1, 0, 0);
    end
    wq.push_back(AB'(8));
    step(0, 0, 2'd1, 1, 1, 0);
    chk_addrs("gap_trig", 2, 0, 8, 0);
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 0) wq.push_back(AB'(9 + i / 2));
      step(0, 0, 2'd1, (i % 2 == 0), 1, 0);
      if (i == 11) chk("gap_still_post", state, 2);
    end
    chk_addrs("gap_done", 3, 0, 8, 15);

    // Abort wins over start; addresses hold
    step(1, 1, 2'd2, 1, 1, 1);
    chk_addrs("abort", 0, 0, 8, 15);
    step(0, 0, 2'd2, 1, 1, 1);
    chk("abort_idle_hold", state, 0);

    // Restart in POST_TRIGGER: start cycle stores nothing, wr_ptr back to 0
    step(1, 0, 2'd1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      wq.push_back(AB'(i));
      step(0, 0, 2'd1, 1, 0, 0);
    end
    wq.push_back(AB'(8));
    step(0, 0, 2'd1, 1, 1, 0);
    chk("restart_in_post", state, 2);
    step(1, 0, 2'd0, 1, 1, 0);
    chk_addrs("restart", 1, 0, 0, 0);
    wq.push_back(AB'(0));
    step(0, 0, 2'd0, 0, 1, 0);
    chk_addrs("restart_trig", 2, 0, 0, 0);
    wq.push_back(AB'(1));
    wq.push_back(AB'(2));
    step(0, 0, 2'd0, 1, 0, 0);
    step(0, 0, 2'd0, 1, 0, 0);

    // Asynchronous reset mid-capture
    store_hit = 1'b1;
    src_reset_ = 1'b0;
    #1;
    chk("rst_mid_state", state, 0);
    chk("rst_mid_wr_ena", ram_wr_ena, 0);
    @(posedge src_clk); #1;
    src_reset_ = 1'b1;
    step(0, 0, 2'd0, 1, 1, 1);
    chk("rst_after_state", state, 0);

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icetap_capture_ctrl.md
# icetap_capture_ctrl

Capture sequencer for the icetap recording BRAM, running entirely in the `src_clk` domain. It accepts start/abort commands plus per-cycle store and trigger qualifiers from the mask-match logic, and drives the BRAM write port as a circular buffer with a programmable pre-/post-trigger split. It publishes capture state and the start, trigger and stop addresses, then sequences the post-capture readout through a request/ready handshake toward the scan side.

## Interface
- `RECORD_DEPTH`, 256, buffer depth in samples; power of two, ≥4.
- `RAM_ADDR_BITS`, `$clog2(RECORD_DEPTH)`, address width.
- `src_clk` in 1: sole clock.
- `src_reset_` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse; begin a new capture.
- `abort` in 1: single-cycle pulse; return to IDLE.
- `trigger_pos` in 2: trigger placement; sampled on `start`.
- `store_hit` in 1: store condition for this cycle's sample.
- `trigger_hit` in 1: trigger condition for this cycle's sample.
- `ram_wr_ena` out 1: BRAM write strobe (combinational).
- `ram_wr_addr` out RAM_ADDR_BITS: BRAM write address.
- `ram_rd_ena` out 1: BRAM read strobe (combinational).
- `ram_rd_addr` out RAM_ADDR_BITS: BRAM read address.
- `state` out 2: 0 IDLE, 1 WAIT_TRIGGER, 2 POST_TRIGGER, 3 DONE.
- `start_addr`, `trigger_addr`, `stop_addr` out RAM_ADDR_BITS each: oldest retained sample, trigger sample, newest sample.
- `signals_out_req` in 1: readout request for the next sample.
- `signals_out_ready` out 1: BRAM read data is valid this cycle.

## Operation
- **PRE selection.** PRE (pre-trigger sample count) is latched on `start` from `trigger_pos`:
  - 0 → PRE = 0
  - 1 or 3 → PRE = DEPTH/2
  - 2 → PRE = DEPTH−1
  - POST = DEPTH−1−PRE.
- **On `start`, from any state:**
  - clear `wr_ptr`, `fill`, `rd_ptr`, and all three address outputs to 0;
  - load `post_cnt` = POST;
  - go to WAIT_TRIGGER.
  - The `start` cycle itself never stores a sample or evaluates a trigger.
- **`abort`:** from any state, go to IDLE. Address outputs hold their values. `abort` wins over a simultaneous `start`.
- **WAIT_TRIGGER:**
  - Trigger is accepted only when `trigger_hit` is high and `fill` ≥ PRE. Triggers before that are ignored.
  - `ram_wr_ena` = `store_hit` | trigger accepted. The trigger sample is always stored, even with `store_hit`=0.
  - Each write goes to `wr_ptr`, then `wr_ptr` increments modulo DEPTH and `fill` increments, saturating at DEPTH.
  - On trigger acceptance:
    - `trigger_addr` ← `wr_ptr`;
    - `start_addr` ← (`wr_ptr` − PRE) mod DEPTH;
    - if POST = 0: `stop_addr` ← `wr_ptr` and go to DONE;
    - otherwise go to POST_TRIGGER.
- **POST_TRIGGER:**
  - `ram_wr_ena` = `store_hit`. `trigger_hit` is ignored.
  - Each write decrements `post_cnt`.
  - The write that takes `post_cnt` 1 → 0 sets `stop_addr` ← `wr_ptr` and moves to DONE.
- **IDLE / DONE:** `ram_wr_ena` = 0.
- **Readout:**
  - On entering DONE, `rd_ptr` ← `start_addr`.
  - In DONE, `signals_out_req` high while `signals_out_ready` is low: `ram_rd_ena` = 1 and `ram_rd_addr` = `rd_ptr`; next cycle `signals_out_ready` = 1 and `rd_ptr` increments modulo DEPTH.
  - Requests in other states, or while `signals_out_ready` is high, are ignored.
  - Reading past `stop_addr` wraps and continues; the host counts DEPTH samples.
- **Arithmetic:** all address arithmetic is RAM_ADDR_BITS wide and wraps naturally. `fill` and `post_cnt` are RAM_ADDR_BITS+1 wide.

## Timing
- **Reset values:** `state` = IDLE; all addresses, pointers and counters = 0; `signals_out_ready` = 0.
- **Write port:** `ram_wr_ena` is combinational from `state`, `store_hit`, `trigger_hit` and `fill`. `ram_wr_addr` is the registered `wr_ptr`. The sample data path aligns to the same cycle as `store_hit`.
- **State and addresses:** `state`, `trigger_addr`, `start_addr` and `stop_addr` update at the clock edge ending the qualifying cycle, so they are visible on the next cycle.
- **Read port:** BRAM read latency is 1, so data is valid when `signals_out_ready` = 1. Maximum readout rate is one sample per 2 cycles.
- **Reset mid-capture:** immediate return to IDLE with no further writes.

## Test plan
- **Middle trigger.** DEPTH=16, `trigger_pos`=1 (PRE=8), `start`, `store_hit`=1 continuously; `trigger_hit` at `fill`=3 → ignored; `trigger_hit` at `fill`=10 → `trigger_addr`=10, `start_addr`=2; 7 more writes → `stop_addr`=1 and `state`=3. Total writes = 18.
- **Trigger at start.** `trigger_pos`=0, `trigger_hit` on the first cycle with `store_hit`=0 → write at addr 0, `start_addr`=0, `trigger_addr`=0; 15 further stores → `stop_addr`=15.
- **Trigger at end.** `trigger_pos`=2, trigger after 20 stores (`wr_ptr`=4) → `trigger_addr`=4, `start_addr`=5, `stop_addr`=4, DONE on the next cycle with no post writes.
- **Gapped stores.** `store_hit` toggling 1/0 in POST_TRIGGER → writes only on hit cycles; `post_cnt` decrements only on writes.
- **Readout.** In DONE with `start_addr`=2, 16 `signals_out_req` pulses → `ram_rd_addr` sequence 2..15, 0, 1; each `signals_out_ready` exactly 1 cycle after its `ram_rd_ena`; a request during `signals_out_ready` is dropped.
- **Abort and reset.** `abort` with `start` in the same cycle → IDLE; `start` in POST_TRIGGER → restart with `wr_ptr`=0; `src_reset_` low mid-capture → IDLE immediately with `ram_wr_ena`=0.
